axi_lite_selftest_master: RTL and testbench
===========================================

# axi_lite_selftest_master

AXI4-Lite master that runs a write/read-back self-test against the S00_AXI register slave of `bus_interface_v1_0`. It sits directly upstream of that slave and drives its AXI4-Lite port in place of the verification BFM. On a start pulse it writes C_NUM_TRANSACTIONS generated words to consecutive word addresses, reading each word back and comparing it immediately after the write. It reports done and a sticky error flag, so the slave can be checked in hardware on the board.

## Interface
- C_M_TARGET_BASE_ADDR, 32'h0000_0000, byte address of the first slave register.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_NUM_TRANSACTIONS, 4, write/read pairs per run; legal range 1..256.
- C_DATA_SEED, 32'h0101FFFF, data for transaction 0.
- C_DATA_STEP, 32'h11111111, per-transaction data increment, modulo 2^32.
- M_AXI_ACLK  in  1  the single clock.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- INIT_TXN  in  1  start request; rising-edge detected.
- TXN_DONE  out  1  high from run completion until the next accepted start.
- ERROR  out  1  sticky error for the current or last run.
- ERR_INDEX  out  8  index of the first failing transaction; valid when ERROR=1.
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  C_M_AXI_DATA_WIDTH  write data.
- M_AXI_WSTRB  out  C_M_AXI_DATA_WIDTH/8  constant all ones.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

## Operation
- Transaction k:
  - Address = C_M_TARGET_BASE_ADDR + 4*k.
  - Data = C_DATA_SEED + k*C_DATA_STEP, kept as a running 32-bit accumulator (no multiplier).
  - The address and data registers are shared by the write and the read of transaction k.
- States:
  - IDLE: on the INIT_TXN rising edge, clear k, ERROR, ERR_INDEX and TXN_DONE, then go to WR.
  - WR: assert AWVALID and WVALID together. Each valid drops independently on its own handshake. BREADY=1 throughout.
    - Go to WAIT_B once both handshakes are done.
    - If BVALID is already high in the same cycle as the last handshake, go straight to RD.
  - WAIT_B: BREADY=1; on BVALID go to RD.
  - RD: assert ARVALID; drop it on the ARREADY handshake. RREADY=1; then go to WAIT_R.
  - WAIT_R: RREADY=1; on RVALID compare, then:
    - if k = C_NUM_TRANSACTIONS-1, go to DONE;
    - otherwise k++ and go to WR.
  - DONE: TXN_DONE=1; on the INIT_TXN rising edge, restart as in IDLE.
- Error conditions, each checked on its handshake cycle:
  - BRESP != 2'b00;
  - RRESP != 2'b00;
  - RDATA != expected data.
- On an error:
  - ERROR is set and stays set until the next start.
  - ERR_INDEX is captured only on the first error of a run.
  - The run continues through all transactions; it does not abort.
- INIT_TXN edges in WR, WAIT_B, RD or WAIT_R are ignored.
- A level held high does not retrigger; a new run needs a 0→1 transition.

## Timing
- Reset values:
  - all VALID and READY outputs = 0;
  - TXN_DONE = 0, ERROR = 0, ERR_INDEX = 0;
  - address and data outputs = 0;
  - state = IDLE;
  - the edge-detect register is cleared to 0.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronously), abandoning any outstanding AXI transfer.
- Start latency: INIT_TXN is sampled high at edge n with a previous sample of 0. AWVALID, WVALID and AWADDR/WDATA become valid after edge n+1.
- All outputs are registered. A VALID deasserts on the clock edge after its handshake (VALID & READY sampled high). Address and data stay stable while VALID is high.
- Minimum transaction cost with an always-ready, zero-wait slave is 4 cycles: WR, WAIT_B, RD, WAIT_R.
- TXN_DONE rises the cycle after the final R handshake.
- ERROR rises the cycle after the failing handshake.

## Test plan
- Default parameters, slave = `bus_interface_v1_0` → writes 0x0101FFFF, 0x12131110, 0x23242221, 0x34353332 to addresses 0x0, 0x4, 0x8, 0xC. Each read returns the same value; TXN_DONE=1, ERROR=0.
- Slave returns RDATA=0x12131111 for k=1 → ERROR=1 and ERR_INDEX=1. The run still completes all 4 transactions and TXN_DONE=1.
- AWREADY delayed 3 cycles while WREADY arrives immediately → WVALID drops after 1 cycle and AWVALID holds for 3. BREADY stays high; no duplicate writes; the data checks pass.
- BRESP=2'b10 on k=2 and a data mismatch on k=3 → ERROR=1 and ERR_INDEX=2, so the first error wins.
- Reset pulsed low during WAIT_R of k=2 → all valids are 0 the same cycle and the state is IDLE. A new INIT_TXN edge restarts from k=0 and the run passes.
- INIT_TXN held high through the whole run, then a second edge mid-run → exactly one run, 8 AXI transfers. TXN_DONE stays high until INIT_TXN goes 0 then 1 again.

Source files
------------

// File: rtl/axi_lite_selftest_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_selftest_master
// Purpose  : AXI4-Lite master that writes C_NUM_TRANSACTIONS generated words
//            to consecutive word addresses of a register slave. Each word is
//            read back and compared right after its write. Completion is
//            reported on TXN_DONE, and a sticky ERROR flag records the index
//            of the first failing transaction.
// Ports    : M_AXI_ACLK / M_AXI_ARESETN - clock, async active-low reset
//            INIT_TXN                   - start request (rising edge)
//            TXN_DONE, ERROR, ERR_INDEX - run status
//            M_AXI_AW*/W*/B*/AR*/R*     - AXI4-Lite master port
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_selftest_master #(
    parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h0000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH   = 32,
    parameter int          C_M_AXI_DATA_WIDTH   = 32,
    parameter int          C_NUM_TRANSACTIONS   = 4,
    parameter logic [31:0] C_DATA_SEED          = 32'h0101_FFFF,
    parameter logic [31:0] C_DATA_STEP          = 32'h1111_1111
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_TXN,
    output logic                              TXN_DONE,
    output logic                              ERROR,
    output logic [7:0]                        ERR_INDEX,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [7:0] LAST_K = 8'(C_NUM_TRANSACTIONS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_WAIT_B = 3'd2,
        S_RD     = 3'd3,
        S_WAIT_R = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                          state_q, state_d;
    logic                            init_q, init_prev_q;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]                      k_q, k_d;
    logic                            done_q, done_d;
    logic                            error_q, error_d;
    logic [7:0]                      err_idx_q, err_idx_d;

    logic                            start_w;
    logic                            aw_ok_w;
    logic                            w_ok_w;
    logic                            fault_w;

    // init_q holds the latest sample of INIT_TXN and init_prev_q the one
    // before it, so a start is recognised one edge after the 0->1 sample.
    assign start_w = init_q & ~init_prev_q;

    // A channel counts as finished when its VALID is already down or its
    // handshake completes this cycle.
    assign aw_ok_w = ~awvalid_q | M_AXI_AWREADY;
    assign w_ok_w  = ~wvalid_q  | M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            init_q      <= 1'b0;
            init_prev_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            k_q         <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_idx_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            init_q      <= INIT_TXN;
            init_prev_q <= init_q;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            k_q         <= k_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_idx_q   <= err_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        data_d    = data_q;
        k_d       = k_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        fault_w   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_w) begin
                    k_d       = 8'd0;
                    error_d   = 1'b0;
                    err_idx_d = 8'd0;
                    done_d    = 1'b0;
                    addr_d    = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_BASE_ADDR);
                    data_d    = C_M_AXI_DATA_WIDTH'(C_DATA_SEED);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    state_d   = S_WR;
                end
            end

            S_WR: begin
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_ok_w && w_ok_w) begin
                    // A slave may answer on the same cycle as the last
                    // address/data handshake; take the response right away.
                    if (M_AXI_BVALID) begin
                        fault_w   = (M_AXI_BRESP != 2'b00);
                        bready_d  = 1'b0;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = S_RD;
                    end else begin
                        state_d   = S_WAIT_B;
                    end
                end
            end

            S_WAIT_B: begin
                if (M_AXI_BVALID) begin
                    fault_w   = (M_AXI_BRESP != 2'b00);
                    bready_d  = 1'b0;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end
            end

            S_RD: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_WAIT_R;
                end
            end

            S_WAIT_R: begin
                if (M_AXI_RVALID) begin
                    fault_w  = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_q);
                    rready_d = 1'b0;
                    if (k_q == LAST_K) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // Running accumulator keeps data = seed + k*step
                        // without a multiplier.
                        k_d       = k_q + 8'd1;
                        addr_d    = addr_q + C_M_AXI_ADDR_WIDTH'(4);
                        data_d    = data_q + C_M_AXI_DATA_WIDTH'(C_DATA_STEP);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = S_WR;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only the first failure of a run records its index.
        if (fault_w) begin
            error_d = 1'b1;
            if (!error_q) begin
                err_idx_d = k_q;
            end
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_INDEX     = err_idx_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_selftest_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_selftest_master
// Purpose  : Self-checking bench for axi_lite_selftest_master. A behavioural
//            register slave with configurable AWREADY delay and fault
//            injection answers the master; a table of runs is applied, then
//            hand-written sequences cover reset mid-run and INIT_TXN held high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_selftest_master;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SEED = 32'h0101_FFFF;
    localparam logic [31:0] STEP = 32'h1111_1111;

    logic        clk;
    logic        rst_n;
    logic        init_txn;
    logic        txn_done, error;
    logic [7:0]  err_index;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi_lite_selftest_master dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .INIT_TXN      (init_txn),
        .TXN_DONE      (txn_done),
        .ERROR         (error),
        .ERR_INDEX     (err_index),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Slave model: decides READY/VALID at each negedge; anything offered
    // there completes on the following posedge.
    // ------------------------------------------------------------------
    int          aw_delay    = 0;
    int          bad_rdata_k = -1;
    int          bad_bresp_k = -1;
    int          bad_rresp_k = -1;

    bit [31:0]   mem [0:15];
    bit          aw_got, w_got, ar_got, bhs, rhs;
    int          aw_cnt;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s;
    int          n_aw = 0, n_w = 0, n_ar = 0, awv_cyc = 0, wv_cyc = 0;

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        aw_got = 0; w_got = 0; ar_got = 0; bhs = 0; rhs = 0; aw_cnt = 0;
        aw_addr_s = '0; w_data_s = '0; ar_addr_s = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
                aw_got = 0; w_got = 0; ar_got = 0; bhs = 0; rhs = 0; aw_cnt = 0;
            end else begin
                if (bvalid && bhs) bvalid = 1'b0;
                if (rvalid && rhs) rvalid = 1'b0;
                if (aw_got && w_got && !bvalid) begin
                    int idx;
                    idx = int'(((aw_addr_s - BASE) >> 2) & 32'hF);
                    mem[idx] = w_data_s;
                    bresp  = (idx == bad_bresp_k) ? 2'b10 : 2'b00;
                    bvalid = 1'b1;
                    aw_got = 0;
                    w_got  = 0;
                end
                if (ar_got && !rvalid) begin
                    int idx;
                    idx = int'(((ar_addr_s - BASE) >> 2) & 32'hF);
                    rdata  = mem[idx] ^ ((idx == bad_rdata_k) ? 32'h1 : 32'h0);
                    rresp  = (idx == bad_rresp_k) ? 2'b10 : 2'b00;
                    rvalid = 1'b1;
                    ar_got = 0;
                end
                awready = 1'b0;
                if (awvalid) awv_cyc++;
                if (awvalid && !aw_got) begin
                    if (aw_cnt >= aw_delay) begin
                        awready = 1'b1; aw_got = 1; aw_addr_s = awaddr;
                        aw_cnt = 0; n_aw++;
                    end else begin
                        aw_cnt++;
                    end
                end
                wready = 1'b0;
                if (wvalid) wv_cyc++;
                if (wvalid && !w_got) begin
                    wready = 1'b1; w_got = 1; w_data_s = wdata; n_w++;
                end
                arready = 1'b0;
                if (arvalid && !ar_got) begin
                    arready = 1'b1; ar_got = 1; ar_addr_s = araddr; n_ar++;
                end
                bhs = bvalid && bready;
                rhs = rvalid && rready;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        int         aw_delay;
        int         bad_rdata;
        int         bad_bresp;
        int         bad_rresp;
        logic       exp_err;
        logic [7:0] exp_idx;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int aw0, w0, ar0, awc0, wc0;
        aw_delay    = v.aw_delay;
        bad_rdata_k = v.bad_rdata;
        bad_bresp_k = v.bad_bresp;
        bad_rresp_k = v.bad_rresp;
        aw0 = n_aw; w0 = n_w; ar0 = n_ar; awc0 = awv_cyc; wc0 = wv_cyc;
        @(negedge clk); init_txn = 1'b1;
        @(negedge clk);
        chk({tag, " awvalid_after_edge_n"}, {31'd0, awvalid}, 32'd0);
        @(negedge clk); init_txn = 1'b0;
        chk({tag, " awvalid_after_edge_n1"}, {31'd0, awvalid}, 32'd1);
        chk({tag, " wvalid_after_edge_n1"}, {31'd0, wvalid}, 32'd1);
        chk({tag, " first_awaddr"}, awaddr, BASE);
        chk({tag, " first_wdata"}, wdata, SEED);
        chk({tag, " done_cleared"}, {31'd0, txn_done}, 32'd0);
        chk({tag, " error_cleared"}, {31'd0, error}, 32'd0);
        cyc = 0;
        while (!txn_done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " run_cycles"}, cyc, 4 * (4 + v.aw_delay));
        chk({tag, " txn_done"}, {31'd0, txn_done}, 32'd1);
        chk({tag, " error"}, {31'd0, error}, {31'd0, v.exp_err});
        chk({tag, " err_index"}, {24'd0, err_index}, {24'd0, v.exp_idx});
        chk({tag, " aw_count"}, n_aw - aw0, 4);
        chk({tag, " w_count"}, n_w - w0, 4);
        chk({tag, " ar_count"}, n_ar - ar0, 4);
        chk({tag, " awvalid_cycles"}, awv_cyc - awc0, 4 * (v.aw_delay + 1));
        chk({tag, " wvalid_cycles"}, wv_cyc - wc0, 4);
        for (int k = 0; k < 4; k++) begin
            chk({tag, $sformatf(" mem[%0d]", k)}, mem[k], SEED + STEP * k);
        end
    endtask

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, -1, -1, -1, 1'b0, 8'd0};  // clean run
        vecs[1] = '{0,  1, -1, -1, 1'b1, 8'd1};  // RDATA mismatch at k=1
        vecs[2] = '{2, -1, -1, -1, 1'b0, 8'd0};  // AWREADY 2 cycles late
        vecs[3] = '{0,  3,  2, -1, 1'b1, 8'd2};  // BRESP k=2 then data k=3
        vecs[4] = '{0, -1, -1,  0, 1'b1, 8'd0};  // RRESP error at k=0
        vecs[5] = '{1,  3, -1, -1, 1'b1, 8'd3};  // error on last transaction

        init_txn = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst wvalid",  {31'd0, wvalid},  32'd0);
        chk("rst bready",  {31'd0, bready},  32'd0);
        chk("rst arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst rready",  {31'd0, rready},  32'd0);
        chk("rst status",  {29'd0, txn_done, error, 1'b0}, 32'd0);
        chk("rst err_index", {24'd0, err_index}, 32'd0);
        chk("rst awaddr", awaddr, 32'd0);
        chk("rst wdata",  wdata,  32'd0);
        chk("prot", {26'd0, awprot, arprot}, 32'd0);
        chk("wstrb", {28'd0, wstrb}, 32'hF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Reset pulsed during WAIT_R of k=2, then a fresh run.
        begin
            int t;
            aw_delay = 0; bad_rdata_k = -1; bad_bresp_k = -1; bad_rresp_k = -1;
            @(negedge clk); init_txn = 1'b1;
            t = 0;
            while (!(rready && !arvalid && araddr == BASE + 32'd8) && t < 200) begin
                @(negedge clk);
                t++;
                if (t == 2) init_txn = 1'b0;
            end
            chk("reach wait_r k2", {31'd0, (t < 200)}, 32'd1);
            init_txn = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("async rst valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
            chk("async rst readies", {30'd0, bready, rready}, 32'd0);
            chk("async rst araddr", araddr, 32'd0);
            chk("async rst done", {31'd0, txn_done}, 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            chk("idle after rst", {31'd0, awvalid}, 32'd0);
            run_vec(vecs[0], "post_rst");
            repeat (3) @(negedge clk);
        end

        // INIT_TXN held high, with an extra edge mid-run.
        begin
            int aw0, ar0, t;
            aw0 = n_aw; ar0 = n_ar;
            @(negedge clk); init_txn = 1'b1;
            repeat (10) @(negedge clk);
            init_txn = 1'b0;
            @(negedge clk); init_txn = 1'b1;
            t = 0;
            while (!txn_done && t < 500) begin
                @(negedge clk);
                t++;
            end
            repeat (20) @(negedge clk);
            chk("held xfers", (n_aw - aw0) + (n_ar - ar0), 8);
            chk("held done", {31'd0, txn_done}, 32'd1);
            chk("held error", {31'd0, error}, 32'd0);
            init_txn = 1'b0;
            @(negedge clk); init_txn = 1'b1;
            @(negedge clk);
            chk("restart done still", {31'd0, txn_done}, 32'd1);
            @(negedge clk);
            chk("restart done clr", {31'd0, txn_done}, 32'd0);
            chk("restart awvalid", {31'd0, awvalid}, 32'd1);
            init_txn = 1'b0;
            t = 0;
            while (!txn_done && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("restart run done", {31'd0, txn_done}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
